// File: rtl/binary_adder_4bit_pkg.sv
// Shared constants and result bundle for the ripple-carry adder.
// Integrators can use adder_result_t to carry {c_out, ovf, sum} around.
package binary_adder_4bit_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef struct packed {
        logic                   c_out;
        logic                   ovf;
        logic [ADDER_WIDTH-1:0] sum;
    } adder_result_t;

endpackage

// File: rtl/binary_adder_4bit_full_adder.sv
// Single-bit full adder cell; one link of the ripple carry chain.
// Ports: a, b, ci in; s (sum bit), co (carry out) out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/binary_adder_4bit.sv
// Registered ripple-carry adder: {c_out,sum} = a + b + c_in, plus ovf.
// Ports: clk, rst_n, a, b, c_in, in_valid in; sum, c_out, ovf, out_valid out.
module binary_adder_4bit
    import binary_adder_4bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Hold the previous result when no operands arrive, so junk on
    // a/b/c_in outside a valid cycle never reaches the outputs.
    always_comb begin
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = s;
            c_out_d = c[WIDTH];
            ovf_d   = c[WIDTH] ^ c[WIDTH-1];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_binary_adder_4bit.sv
// Directed-vector and exhaustive bench for binary_adder_4bit.
// Drives on falling edges, compares one cycle later on the next one.
module tb_binary_adder_4bit;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic       in_valid;
    logic [3:0] sum;
    logic       c_out;
    logic       ovf;
    logic       out_valid;

    int checks;
    int errors;

    vec_t tbl [10];

    binary_adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {c_out, ovf, sum, out_valid} against the expected tuple.
    task automatic chk(input string nm, input logic [3:0] es,
                       input logic ec, input logic eo, input logic ev);
        logic [6:0] act;
        logic [6:0] exp;
        act = {c_out, ovf, sum, out_valid};
        exp = {ec, eo, es, ev};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got co=%b ov=%b s=%b v=%b want co=%b ov=%b s=%b v=%b",
                     nm, act[6], act[5], act[4:1], act[0],
                     exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                         input logic vc, input logic vv);
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = vv;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int s_u;
        int s_s;
        int sa;
        int sb;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       ec;
        logic [3:0] es;
        logic       eco;
        logic       eov;

        checks = 0;
        errors = 0;

        tbl[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1};
        tbl[2] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[3] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[4] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        tbl[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        tbl[6] = '{4'h8, 4'hF, 1'b0, 4'h7, 1'b1, 1'b1};
        tbl[7] = '{4'h6, 4'h1, 1'b1, 4'h8, 1'b0, 1'b1};
        tbl[8] = '{4'h9, 4'h2, 1'b0, 4'hB, 1'b0, 1'b0};
        tbl[9] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        #2;
        chk("reset_init", 4'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, back-to-back; last entry is all-ones + 1.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b1);
            cycle();
            chk($sformatf("vec%0d", i),
                tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1);
        end

        // Idle: outputs hold 1111/c1/ov0, valid drops.
        drive(4'h6, 4'h3, 1'b1, 1'b0);
        cycle();
        chk("hold1", 4'hF, 1'b1, 1'b0, 1'b0);
        drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        cycle();
        chk("hold2", 4'hF, 1'b1, 1'b0, 1'b0);
        a    = 4'bxxxx;
        b    = 4'bxxxx;
        c_in = 1'bx;
        cycle();
        chk("hold_x", 4'hF, 1'b1, 1'b0, 1'b0);

        // Reset asserted mid-cycle with a nonzero result registered.
        drive(4'h3, 4'h5, 1'b0, 1'b1);
        cycle();
        chk("pre_rst", 4'h8, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_held", 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(4'h2, 4'h4, 1'b1, 1'b1);
        #1;
        chk("post_rel", 4'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("first_val", 4'h7, 1'b0, 1'b0, 1'b1);

        // Exhaustive sweep, back-to-back, against an arithmetic model.
        for (int i = 0; i < 512; i++) begin
            ea = 4'(i);
            eb = 4'(i >> 4);
            ec = 1'(i >> 8);
            drive(ea, eb, ec, 1'b1);
            s_u = int'(ea) + int'(eb) + int'(ec);
            sa  = (ea >= 4'd8) ? int'(ea) - 16 : int'(ea);
            sb  = (eb >= 4'd8) ? int'(eb) - 16 : int'(eb);
            s_s = sa + sb + int'(ec);
            es  = 4'(s_u);
            eco = (s_u >= 16);
            eov = (s_s > 7) || (s_s < -8);
            cycle();
            chk($sformatf("sweep a=%0d b=%0d c=%0d", ea, eb, ec),
                es, eco, eov, 1'b1);
        end

        in_valid = 1'b0;
        cycle();
        chk("sweep_end", 4'hF, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
